// File: rtl/stack_register_file.sv
// CPU register file with PC, parameter/return stack pointers and OfR at fixed slots.
// Two registered read ports, bounded push/pop with sticky error flags, PC increment.
module stack_register_file #(
  parameter int DATA_W   = 16,
  parameter int NREGS    = 16,
  parameter int PSP_BASE = 48,
  parameter int PSP_SIZE = 8,
  parameter int RSP_BASE = 56,
  parameter int RSP_SIZE = 8,
  parameter int BYPASS   = 1,
  localparam int ADDR_W  = $clog2(NREGS)
) (
  input  logic              c_CLOCK,
  input  logic              c_RESET,
  input  logic [ADDR_W-1:0] i_RADDRA,
  input  logic [ADDR_W-1:0] i_RADDRB,
  output logic [DATA_W-1:0] o_OUTA,
  output logic [DATA_W-1:0] o_OUTB,
  input  logic [ADDR_W-1:0] i_WADDR,
  input  logic [DATA_W-1:0] i_DATA,
  input  logic              f_WRITE,
  input  logic [DATA_W-1:0] i_PCDATA,
  input  logic              f_PCWRITE,
  input  logic              f_PCINC,
  input  logic [1:0]        i_PSPOP,
  input  logic [1:0]        i_RSPOP,
  input  logic [1:0]        i_SSRSet,
  input  logic              f_CLRERR,
  output logic              o_SSR,
  output logic [DATA_W-1:0] o_PC,
  output logic [DATA_W-1:0] o_PSP,
  output logic [DATA_W-1:0] o_RSP,
  output logic [DATA_W-1:0] o_OfR,
  output logic              o_PSPOVF,
  output logic              o_PSPUNF,
  output logic              o_RSPOVF,
  output logic              o_RSPUNF
);

  localparam logic [DATA_W-1:0] PSP_LO = DATA_W'(PSP_BASE);
  localparam logic [DATA_W-1:0] PSP_HI = DATA_W'(PSP_BASE + PSP_SIZE);
  localparam logic [DATA_W-1:0] RSP_LO = DATA_W'(RSP_BASE);
  localparam logic [DATA_W-1:0] RSP_HI = DATA_W'(RSP_BASE + RSP_SIZE);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [DATA_W-1:0] outA_q, outA_d, outB_q, outB_d;
  logic              ssr_q, ssr_d;
  logic              pspOvf_q, pspOvf_d, pspUnf_q, pspUnf_d;
  logic              rspOvf_q, rspOvf_d, rspUnf_q, rspUnf_d;
  logic              pspOvfSet, pspUnfSet, rspOvfSet, rspUnfSet;

  // A general write to a slot pre-empts that slot's dedicated update path.
  always_comb begin
    regs_d    = regs_q;
    pspOvfSet = 1'b0;
    pspUnfSet = 1'b0;
    rspOvfSet = 1'b0;
    rspUnfSet = 1'b0;

    if (f_WRITE) regs_d[i_WADDR] = i_DATA;

    if (!(f_WRITE && i_WADDR == ADDR_W'(0))) begin
      if (f_PCWRITE)    regs_d[0] = i_PCDATA;
      else if (f_PCINC) regs_d[0] = regs_q[0] + DATA_W'(1);
    end

    if (!(f_WRITE && i_WADDR == ADDR_W'(1))) begin
      case (i_PSPOP)
        2'b01: if (regs_q[1] >= PSP_HI) pspOvfSet = 1'b1;
               else regs_d[1] = regs_q[1] + DATA_W'(1);
        2'b10: if (regs_q[1] <= PSP_LO) pspUnfSet = 1'b1;
               else regs_d[1] = regs_q[1] - DATA_W'(1);
        default: ;
      endcase
    end

    if (!(f_WRITE && i_WADDR == ADDR_W'(2))) begin
      case (i_RSPOP)
        2'b01: if (regs_q[2] >= RSP_HI) rspOvfSet = 1'b1;
               else regs_d[2] = regs_q[2] + DATA_W'(1);
        2'b10: if (regs_q[2] <= RSP_LO) rspUnfSet = 1'b1;
               else regs_d[2] = regs_q[2] - DATA_W'(1);
        default: ;
      endcase
    end
  end

  // A fresh error outranks a simultaneous clear.
  always_comb begin
    pspOvf_d = (pspOvf_q & ~f_CLRERR) | pspOvfSet;
    pspUnf_d = (pspUnf_q & ~f_CLRERR) | pspUnfSet;
    rspOvf_d = (rspOvf_q & ~f_CLRERR) | rspOvfSet;
    rspUnf_d = (rspUnf_q & ~f_CLRERR) | rspUnfSet;
    case (i_SSRSet)
      2'd0:    ssr_d = 1'b0;
      2'd1:    ssr_d = 1'b1;
      default: ssr_d = ssr_q;
    endcase
    outA_d = (BYPASS != 0) ? regs_d[i_RADDRA] : regs_q[i_RADDRA];
    outB_d = (BYPASS != 0) ? regs_d[i_RADDRB] : regs_q[i_RADDRB];
  end

  always_ff @(posedge c_CLOCK) begin
    if (c_RESET) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      regs_q[1] <= PSP_LO;
      regs_q[2] <= RSP_LO;
      outA_q    <= '0;
      outB_q    <= '0;
      ssr_q     <= 1'b0;
      pspOvf_q  <= 1'b0;
      pspUnf_q  <= 1'b0;
      rspOvf_q  <= 1'b0;
      rspUnf_q  <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      outA_q    <= outA_d;
      outB_q    <= outB_d;
      ssr_q     <= ssr_d;
      pspOvf_q  <= pspOvf_d;
      pspUnf_q  <= pspUnf_d;
      rspOvf_q  <= rspOvf_d;
      rspUnf_q  <= rspUnf_d;
    end
  end

  assign o_OUTA   = outA_q;
  assign o_OUTB   = outB_q;
  assign o_SSR    = ssr_q;
  assign o_PC     = regs_q[0];
  assign o_PSP    = regs_q[1];
  assign o_RSP    = regs_q[2];
  assign o_OfR    = regs_q[3];
  assign o_PSPOVF = pspOvf_q;
  assign o_PSPUNF = pspUnf_q;
  assign o_RSPOVF = rspOvf_q;
  assign o_RSPUNF = rspUnf_q;

endmodule
